// File: rtl/uart_rx_os_pkg.sv
// Shared types, constants and helpers for the oversampled UART receiver
// and its baud-tick generator.
package uart_rx_os_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Oversample tick divider, floored, never below one clock.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        if (d < 1) begin
            return 1;
        end else begin
            return d;
        end
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-side port of the UART receiver: data, valid/ready handshake and
// the error flags that travel with it.
interface uart_rx_os_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output dout,
    output dout_valid,
    output frame_err,
    output overrun,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  overrun,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_os_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable
// so the sampling phase can be locked to a start edge.
module uart_baud_tick
  import uart_rx_os_pkg::*;
#(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600,
  parameter int OS       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD, OS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Next count: restart on clear, wrap at the last phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and registered tick, high whenever the count sits at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 UART receiver with 3-sample majority vote, glitch-start
// rejection, framing-error pulse and a one-entry valid/ready holding register.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600,
  parameter int OS       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            busy,
  uart_rx_os_if.master    dbus
);
  localparam int OSW = $clog2(OS);
  localparam logic [OSW-1:0] S_LO  = OSW'(OS/2 - 1);
  localparam logic [OSW-1:0] S_MID = OSW'(OS/2);
  localparam logic [OSW-1:0] S_HI  = OSW'(OS/2 + 1);
  localparam logic [OSW-1:0] S_END = OSW'(OS - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic           sync1_q, sync2_q;
  uart_rx_state_t state_q;
  logic [OSW-1:0] os_q;
  logic [2:0]     bit_q;
  logic [1:0]     samp_q;
  logic [7:0]     shift_q;
  logic           armed_q;
  logic           busy_q;
  logic [7:0]     dout_q;
  logic           dout_valid_q, frame_err_q, overrun_q;

  logic           rx_s, tick_s, start_s, vote_s, vote_tick_s;
  logic           deliver_s, ferr_s;
  logic [OSW-1:0] os_nxt_s;

  // Two-flop synchronizer, preset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  // A new start is only armed once the line has been seen high in IDLE,
  // so a held-low break produces a single framing error.
  assign start_s     = (state_q == RX_IDLE) && armed_q && !rx_s;
  assign vote_tick_s = tick_s && (os_q == S_HI);
  assign vote_s      = maj3(samp_q[1], samp_q[0], rx_s);
  assign os_nxt_s    = (os_q == S_END) ? '0 : os_q + OSW'(1);
  assign deliver_s   = (state_q == RX_STOP) && vote_tick_s && vote_s;
  assign ferr_s      = (state_q == RX_STOP) && vote_tick_s && !vote_s;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OS       (OS)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_s),
    .tick  (tick_s)
  );

  // Capture the first two of the three vote samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= 2'b11;
    end else if (tick_s && (os_q == S_LO)) begin
      samp_q[1] <= rx_s;
    end else if (tick_s && (os_q == S_MID)) begin
      samp_q[0] <= rx_s;
    end else begin
      samp_q <= samp_q;
    end
  end

  // Receive FSM with registered busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      os_q    <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end
          if (start_s) begin
            state_q <= RX_START;
            os_q    <= '0;
            bit_q   <= 3'd0;
            busy_q  <= 1'b1;
          end
        end
        RX_START: begin
          if (tick_s) begin
            os_q <= os_nxt_s;
            if (vote_tick_s && vote_s) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else if (os_q == S_END) begin
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tick_s) begin
            os_q <= os_nxt_s;
            if (vote_tick_s) begin
              shift_q <= {vote_s, shift_q[7:1]};
            end
            if (os_q == S_END) begin
              if (bit_q == LAST_BIT) begin
                state_q <= RX_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick_s) begin
            os_q <= os_nxt_s;
            // Leave at mid stop bit so the next start edge is caught early.
            if (vote_tick_s) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
              armed_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: accept frees it, a delivery into a full unaccepted
  // register is dropped and flagged as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= ferr_s;
      if (dout_valid_q && dbus.dout_ready) begin
        dout_valid_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
      if (deliver_s) begin
        if (!dout_valid_q || dbus.dout_ready) begin
          dout_q       <= shift_q;
          dout_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign busy            = busy_q;
  assign dbus.dout       = dout_q;
  assign dbus.dout_valid = dout_valid_q;
  assign dbus.frame_err  = frame_err_q;
  assign dbus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1 MHz / 9600 baud / 16x (96 clk per bit).
module tb_uart_rx_os;
  localparam int BIT_CLK = 96;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic busy;

  uart_rx_os_if u_if();

  uart_rx_os #(.CLK_FREQ(1000000), .BAUD(9600), .OS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .busy  (busy),
    .dbus  (u_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Output monitor, sampled on the falling edge.
  int         acc_n  = 0;
  int         vcyc_n = 0;
  int         ferr_n = 0;
  logic [7:0] last_acc = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.dout_valid) vcyc_n <= vcyc_n + 1;
      if (u_if.frame_err)  ferr_n <= ferr_n + 1;
      if (u_if.dout_valid && u_if.dout_ready) begin
        acc_n    <= acc_n + 1;
        last_acc <= u_if.dout;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Frame BFM; gbit/goff invert one clock of frame bit gbit (0=start) at offset goff.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int gbit, input int goff);
    logic [9:0] f;
    f = {stop_v, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < BIT_CLK; k++) begin
        @(negedge clk);
        rx = f[b] ^ ((b == gbit) && (k == goff));
      end
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_acc;
    logic [7:0] exp_dout;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int a0, v0, f0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};

    u_if.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout",    {24'd0, u_if.dout}, 32'h0);
    chk("reset_valid",   {31'd0, u_if.dout_valid}, 32'h0);
    chk("reset_ferr",    {31'd0, u_if.frame_err}, 32'h0);
    chk("reset_overrun", {31'd0, u_if.overrun}, 32'h0);
    chk("reset_busy",    {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(20);

    // Table-driven frames with ready held high.
    for (int i = 0; i < 6; i++) begin
      a0 = acc_n; v0 = vcyc_n; f0 = ferr_n;
      send_frame(vecs[i].data, vecs[i].stop_v, -1, 0);
      idle(2 * BIT_CLK);
      chk($sformatf("vec%0d_accepts", i), acc_n - a0, vecs[i].exp_acc);
      chk($sformatf("vec%0d_valid_cycles", i), vcyc_n - v0, vecs[i].exp_acc);
      chk($sformatf("vec%0d_ferr_cycles", i), ferr_n - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_acc == 1) chk($sformatf("vec%0d_dout", i), {24'd0, last_acc}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'h0);
      chk($sformatf("vec%0d_overrun", i), {31'd0, u_if.overrun}, 32'h0);
    end

    // Valid rises one clock after the stop-bit vote (~927 clk after start edge).
    a0 = acc_n;
    fork
      send_frame(8'h5A, 1'b1, -1, 0);
      begin
        repeat (900) @(negedge clk);
        chk("lat_busy_in_frame", {31'd0, busy}, 32'h1);
        chk("lat_not_early", acc_n - a0, 0);
        repeat (40) @(negedge clk);
        chk("lat_delivered", acc_n - a0, 1);
        chk("lat_busy_after_vote", {31'd0, busy}, 32'h0);
      end
    join
    idle(BIT_CLK);

    // Glitch start: 20 clk low pulse.
    a0 = acc_n; f0 = ferr_n;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rx = (k < 20) ? 1'b0 : 1'b1;
      if (k == 30) chk("glitch_busy_high", {31'd0, busy}, 32'h1);
      if (k == 70) chk("glitch_busy_low", {31'd0, busy}, 32'h0);
    end
    idle(2 * BIT_CLK);
    chk("glitch_no_valid", acc_n - a0, 0);
    chk("glitch_no_ferr", ferr_n - f0, 0);

    // Overrun with ready low.
    u_if.dout_ready = 1'b0;
    a0 = acc_n;
    send_frame(8'h11, 1'b1, -1, 0);
    idle(BIT_CLK);
    chk("ovr_first_valid", {31'd0, u_if.dout_valid}, 32'h1);
    chk("ovr_first_dout", {24'd0, u_if.dout}, 32'h11);
    chk("ovr_first_flag", {31'd0, u_if.overrun}, 32'h0);
    send_frame(8'h22, 1'b1, -1, 0);
    idle(BIT_CLK);
    chk("ovr_held_dout", {24'd0, u_if.dout}, 32'h11);
    chk("ovr_flag_set", {31'd0, u_if.overrun}, 32'h1);
    u_if.dout_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", {31'd0, u_if.dout_valid}, 32'h0);
    chk("ovr_flag_cleared", {31'd0, u_if.overrun}, 32'h0);
    chk("ovr_accepted_byte", {24'd0, last_acc}, 32'h11);
    chk("ovr_accept_count", acc_n - a0, 1);

    // One-clock glitch on data bit 3 at its middle sample.
    a0 = acc_n;
    send_frame(8'h55, 1'b1, 4, 54);
    idle(BIT_CLK);
    chk("maj_accepts", acc_n - a0, 1);
    chk("maj_dout", {24'd0, last_acc}, 32'h55);

    // Break: line held low well past a frame.
    a0 = acc_n; f0 = ferr_n;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      rx = 1'b0;
      if (k == 1200) chk("break_busy_idle", {31'd0, busy}, 32'h0);
    end
    idle(200);
    chk("break_one_ferr", ferr_n - f0, 1);
    chk("break_no_valid", acc_n - a0, 0);
    send_frame(8'hC3, 1'b1, -1, 0);
    idle(BIT_CLK);
    chk("break_recover", {24'd0, last_acc}, 32'hC3);

    // Reset mid-DATA of 0xFF, then a clean 0x81.
    a0 = acc_n; f0 = ferr_n;
    for (int k = 0; k < BIT_CLK; k++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(200);
    rst_n = 1'b0;
    idle(3);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(8 * BIT_CLK);
    chk("rst_no_valid", acc_n - a0, 0);
    send_frame(8'h81, 1'b1, -1, 0);
    idle(BIT_CLK);
    chk("rst_accepts", acc_n - a0, 1);
    chk("rst_dout", {24'd0, last_acc}, 32'h81);
    chk("rst_no_ferr", ferr_n - f0, 0);
    chk("rst_no_overrun", {31'd0, u_if.overrun}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
